// File: rtl/gain_shift_pkg.sv
// rtl/gain_shift_pkg.sv - shared sizing functions, saturation limits and direction type for gain_shift_pipe
package gain_shift_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic int fw(input int dw, input int sw);
        return dw + (1 << sw) - 1;
    endfunction

    function automatic int ns(input int sw);
        return (sw + 1) / 2;
    endfunction

    function automatic int lat(input int sw);
        return ns(sw) + 1;
    endfunction

    // Limits are returned 64 bits wide; callers truncate to OW.
    function automatic logic [63:0] sat_max(input int ow);
        return (64'd1 << (ow - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int ow);
        return ~sat_max(ow);
    endfunction

endpackage

// File: rtl/gain_shift_if.sv
// rtl/gain_shift_if.sv - sample in / result out bundle for gain_shift_pipe
interface gain_shift_if #(
    parameter int DW = 24,
    parameter int SW = 5,
    parameter int OW = 32
);
    logic          in_valid;
    logic [DW-1:0] d;
    logic [SW-1:0] n;
    logic          dir;
    logic          out_valid;
    logic [OW-1:0] q;
    logic          ovf;

    modport master (output in_valid, d, n, dir, input out_valid, q, ovf);
    modport slave  (input in_valid, d, n, dir, output out_valid, q, ovf);
endinterface

// File: rtl/gain_shift_stage.sv
// rtl/gain_shift_stage.sv - one registered radix-4 (radix-2 if last odd bit) shift stage
module gain_shift_stage
    import gain_shift_pkg::*;
#(
    parameter int IDX = 0,
    parameter int FW  = 55,
    parameter int SW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          i_valid,
    input  logic [FW-1:0] i_data,
    input  logic [SW-1:0] i_n,
    input  dir_e          i_dir,
    output logic          o_valid,
    output logic [FW-1:0] o_data,
    output logic [SW-1:0] o_n,
    output dir_e          o_dir
);

    logic [1:0]    w_dig;
    logic [SW-1:0] w_amt;
    logic [FW-1:0] w_shl;
    logic [FW-1:0] w_shr;

    generate
        if (2 * IDX + 1 < SW) begin : g_r4
            assign w_dig = i_n[2*IDX+1 -: 2];
        end else begin : g_r2
            assign w_dig = {1'b0, i_n[2*IDX]};
        end
    endgenerate

    assign w_amt = SW'(w_dig) << (2 * IDX);
    assign w_shl = i_data << w_amt;
    assign w_shr = $signed(i_data) >>> w_amt;

    logic          r_valid;
    logic [FW-1:0] r_data;
    logic [SW-1:0] r_n;
    dir_e          r_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_n     <= '0;
            r_dir   <= DIR_LEFT;
        end else if (ce) begin
            r_valid <= i_valid;
            r_data  <= (i_dir == DIR_RIGHT) ? w_shr : w_shl;
            r_n     <= i_n;
            r_dir   <= i_dir;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_n     = r_n;
    assign o_dir   = r_dir;

endmodule

// File: rtl/gain_shift_pipe.sv
// rtl/gain_shift_pipe.sv - pipelined signed barrel shifter with width reduction; GAIN_SHIFT_SAT_EN selects saturation
module gain_shift_pipe
    import gain_shift_pkg::*;
#(
    parameter int DW = 24,
    parameter int SW = 5,
    parameter int OW = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    gain_shift_if.slave bus
);

    localparam int FW = fw(DW, SW);
    localparam int NS = ns(SW);

    logic [FW-1:0] w_data  [0:NS];
    logic [SW-1:0] w_n     [0:NS];
    dir_e          w_dir   [0:NS];
    logic          w_valid [0:NS];

    assign w_data[0]  = {{(FW-DW){bus.d[DW-1]}}, bus.d};
    assign w_n[0]     = bus.n;
    assign w_dir[0]   = dir_e'(bus.dir);
    assign w_valid[0] = bus.in_valid;

    generate
        for (genvar k = 0; k < NS; k++) begin : g_stage
            gain_shift_stage #(
                .IDX (k),
                .FW  (FW),
                .SW  (SW)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .ce      (ce),
                .i_valid (w_valid[k]),
                .i_data  (w_data[k]),
                .i_n     (w_n[k]),
                .i_dir   (w_dir[k]),
                .o_valid (w_valid[k+1]),
                .o_data  (w_data[k+1]),
                .o_n     (w_n[k+1]),
                .o_dir   (w_dir[k+1])
            );
        end
    endgenerate

    // Result fits in OW bits only when every bit above the OW sign bit copies it.
    logic [FW-1:0]  w_full;
    logic [FW-OW:0] w_hi;
    logic           w_ovf;
    logic [OW-1:0]  w_q;

    assign w_full = w_data[NS];
    assign w_hi   = w_full[FW-1:OW-1];
    assign w_ovf  = ~((&w_hi) | ~(|w_hi));

`ifdef GAIN_SHIFT_SAT_EN
    localparam logic [OW-1:0] SAT_MAX = OW'(sat_max(OW));
    localparam logic [OW-1:0] SAT_MIN = OW'(sat_min(OW));

    always_comb begin
        w_q = w_full[OW-1:0];
        if (w_ovf) begin
            w_q = w_full[FW-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        w_q = w_full[OW-1:0];
    end
`endif

    logic          r_out_valid;
    logic [OW-1:0] r_q;
    logic          r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_ovf       <= 1'b0;
        end else if (ce) begin
            r_out_valid <= w_valid[NS];
            r_q         <= w_q;
            r_ovf       <= w_ovf;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q;
    assign bus.ovf       = r_ovf;

endmodule
